// File: rtl/lif_pkg.sv
// Shared types, constants and arithmetic helpers for the LIF timestep scheduler.
package lif_pkg;

   localparam int LEAK_W = 3;

   // FSM encoding kept as plain constants so it stays legacy-tool friendly.
   typedef logic [1:0] state_t;
   localparam state_t ST_IDLE   = 2'd0;
   localparam state_t ST_FETCH  = 2'd1;
   localparam state_t ST_UPDATE = 2'd2;
   localparam state_t ST_DONE   = 2'd3;

   // Leak: u - (u >> leak); a shift of zero means "no leak" rather than "leak everything".
   function automatic logic [31:0] leak_apply(input logic [31:0] u,
                                              input logic [LEAK_W-1:0] leak);
      if (leak == '0) return u;
      return u - (u >> leak);
   endfunction

   // Unsigned add that clamps at the all-ones value of a w-bit word.
   function automatic logic [31:0] sat_add(input logic [31:0] a,
                                           input logic [31:0] b,
                                           input int w);
      logic [32:0] s;
      logic [31:0] max_val;
      max_val = (w >= 32) ? '1 : ((32'd1 << w) - 32'd1);
      s       = {1'b0, a} + {1'b0, b};
      if (s > {1'b0, max_val}) return max_val;
      return s[31:0];
   endfunction

endpackage

// File: rtl/lif_step_scheduler_update.sv
// Combinational leak / integrate / fire for one neuron.
module lif_update
   import lif_pkg::*;
#(
   parameter int MEM_W = 8
) (
   input  logic [MEM_W-1:0]  u,
   input  logic [MEM_W-1:0]  curr,
   input  logic [MEM_W-1:0]  threshold,
   input  logic [LEAK_W-1:0] leak,
   output logic [MEM_W-1:0]  u_next,
   output logic              spike
);

   logic [MEM_W-1:0] leaked;
   logic [MEM_W-1:0] sum;

   // Leak the membrane, add the input current with saturation, fire and reset on threshold.
   always_comb begin
      leaked = MEM_W'(leak_apply(32'(u), leak));
      sum    = MEM_W'(sat_add(32'(leaked), 32'(curr), MEM_W));
      spike  = (sum >= threshold);
      u_next = spike ? '0 : sum;
   end

endmodule

// File: rtl/lif_step_scheduler.sv
// Timestep controller: walks every virtual neuron through one shared LIF update unit.
module lif_step_scheduler
   import lif_pkg::*;
#(
   parameter int                N_NEURONS  = 4,
   parameter int                MEM_W      = 8,
   parameter logic [MEM_W-1:0]  THRESH_RST = MEM_W'(100),
   parameter logic [LEAK_W-1:0] LEAK_RST   = LEAK_W'(2)
) (
   input  logic                         clk,
   input  logic                         rst,
   input  logic                         step_valid,
   output logic                         step_ready,
   input  logic                         cfg_we,
   input  logic [MEM_W-1:0]             cfg_thresh,
   input  logic [LEAK_W-1:0]            cfg_leak,
   input  logic                         mem_clear,
   output logic [$clog2(N_NEURONS)-1:0] curr_addr,
   input  logic [MEM_W-1:0]             curr_data,
   output logic [N_NEURONS-1:0]         spike_out,
   output logic                         spike_valid,
   output logic                         busy
);

   localparam int IDX_W = $clog2(N_NEURONS);
   localparam logic [IDX_W-1:0] IDX_LAST = IDX_W'(N_NEURONS - 1);

   state_t               state_q,  state_d;
   logic [IDX_W-1:0]     idx_q,    idx_d;
   logic [IDX_W-1:0]     addr_q,   addr_d;
   logic [N_NEURONS-1:0] acc_q,    acc_d;
   logic [N_NEURONS-1:0] spk_q,    spk_d;
   logic [MEM_W-1:0]     thresh_q, thresh_d;
   logic [LEAK_W-1:0]    leak_q,   leak_d;
   logic [MEM_W-1:0]     mem_q [N_NEURONS];
   logic [MEM_W-1:0]     mem_d [N_NEURONS];

   logic [MEM_W-1:0]     u_next;
   logic                 spike;

   lif_update #(.MEM_W(MEM_W)) u_update (
      .u         (mem_q[idx_q]),
      .curr      (curr_data),
      .threshold (thresh_q),
      .leak      (leak_q),
      .u_next    (u_next),
      .spike     (spike)
   );

   // Next-state logic: FSM, index walk, membrane write-back, spike assembly, IDLE-only config.
   always_comb begin
      // NOTE: every variable gets its hold value first so no path through the case infers a latch.
      state_d  = state_q;
      idx_d    = idx_q;
      addr_d   = addr_q;
      acc_d    = acc_q;
      spk_d    = spk_q;
      thresh_d = thresh_q;
      leak_d   = leak_q;
      mem_d    = mem_q;

      case (state_q)
         ST_IDLE: begin
            if (cfg_we) begin
               thresh_d = cfg_thresh;
               leak_d   = cfg_leak;
            end
            if (mem_clear) begin
               for (int i = 0; i < N_NEURONS; i++) mem_d[i] = '0;
            end
            if (step_valid) begin
               idx_d   = '0;
               addr_d  = '0;
               acc_d   = '0;
               state_d = ST_FETCH;
            end
         end
         ST_FETCH: begin
            addr_d  = idx_q;
            state_d = ST_UPDATE;
         end
         ST_UPDATE: begin
            mem_d[idx_q] = u_next;
            acc_d[idx_q] = spike;
            if (idx_q == IDX_LAST) begin
               // Publish the finished vector on entry to DONE so it is valid alongside the pulse.
               spk_d   = acc_d;
               state_d = ST_DONE;
            end else begin
               idx_d   = idx_q + 1'b1;
               addr_d  = idx_q + 1'b1;
               state_d = ST_FETCH;
            end
         end
         ST_DONE: begin
            state_d = ST_IDLE;
         end
         default: begin
            state_d = ST_IDLE;
         end
      endcase
   end

   // State registers with asynchronous reset back to the power-up configuration.
   always_ff @(posedge clk or posedge rst) begin
      // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
      if (rst) begin
         state_q  <= ST_IDLE;
         idx_q    <= '0;
         addr_q   <= '0;
         acc_q    <= '0;
         spk_q    <= '0;
         thresh_q <= THRESH_RST;
         leak_q   <= LEAK_RST;
         // NOTE: the membrane array is a handful of flops, not a RAM, so it can and must reset to 0.
         for (int i = 0; i < N_NEURONS; i++) mem_q[i] <= '0;
      end else begin
         state_q  <= state_d;
         idx_q    <= idx_d;
         addr_q   <= addr_d;
         acc_q    <= acc_d;
         spk_q    <= spk_d;
         thresh_q <= thresh_d;
         leak_q   <= leak_d;
         mem_q    <= mem_d;
      end
   end

   assign step_ready  = (state_q == ST_IDLE);
   assign busy        = (state_q != ST_IDLE);
   assign spike_valid = (state_q == ST_DONE);
   assign spike_out   = spk_q;
   assign curr_addr   = addr_q;

endmodule

// File: tb/tb_lif_step_scheduler.sv
// Scoreboard bench for lif_step_scheduler: directed steps with hand-computed spike vectors.
module tb_lif_step_scheduler;

   localparam int N = 4;
   localparam int W = 8;

   logic         clk = 1'b0;
   logic         rst = 1'b1;
   logic         step_valid = 1'b0;
   logic         step_ready;
   logic         cfg_we = 1'b0;
   logic [W-1:0] cfg_thresh = '0;
   logic [2:0]   cfg_leak = '0;
   logic         mem_clear = 1'b0;
   logic [1:0]   curr_addr;
   logic [W-1:0] curr_data;
   logic [N-1:0] spike_out;
   logic         spike_valid;
   logic         busy;

   lif_step_scheduler #(
      .N_NEURONS (N),
      .MEM_W     (W)
   ) dut (
      .clk         (clk),
      .rst         (rst),
      .step_valid  (step_valid),
      .step_ready  (step_ready),
      .cfg_we      (cfg_we),
      .cfg_thresh  (cfg_thresh),
      .cfg_leak    (cfg_leak),
      .mem_clear   (mem_clear),
      .curr_addr   (curr_addr),
      .curr_data   (curr_data),
      .spike_out   (spike_out),
      .spike_valid (spike_valid),
      .busy        (busy)
   );

   always #5 clk = ~clk;

   // Current source with synchronous-RAM timing.
   logic [W-1:0] curr_mem [N];
   always @(posedge clk) curr_data <= curr_mem[curr_addr];

   int           checks = 0;
   int           errors = 0;
   logic [N-1:0] exp_q [$];
   logic [N-1:0] mon_exp;

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
      end
   endtask

   // Monitor: every spike_valid pulse is matched against the oldest expected vector.
   always @(negedge clk) begin
      if (!rst && spike_valid === 1'b1) begin
         if (exp_q.size() == 0) begin
            errors++;
            $display("FAIL unexpected_spike_valid: got spike_out %b expected no pulse", spike_out);
         end else begin
            mon_exp = exp_q.pop_front();
            check("spike_vec", 32'(spike_out), 32'(mon_exp));
         end
      end
   end

   task automatic set_curr(input logic [W-1:0] c0, c1, c2, c3);
      curr_mem[0] = c0;
      curr_mem[1] = c1;
      curr_mem[2] = c2;
      curr_mem[3] = c3;
   endtask

   task automatic do_cfg(input logic [W-1:0] th, input logic [2:0] lk, input logic clr);
      @(negedge clk);
      cfg_we     = 1'b1;
      cfg_thresh = th;
      cfg_leak   = lk;
      mem_clear  = clr;
      @(negedge clk);
      cfg_we    = 1'b0;
      mem_clear = 1'b0;
   endtask

   // One timestep. sc_cfg: load cfg in the accept cycle. poke: 1 = cfg_we thresh 10 while busy,
   // 2 = mem_clear while busy. Completion must come exactly 10 cycles after the accept edge.
   task automatic run_step(input logic [N-1:0] exp, input logic sc_cfg, input int poke);
      int n;
      @(negedge clk);
      exp_q.push_back(exp);
      step_valid = 1'b1;
      if (sc_cfg) cfg_we = 1'b1;
      @(negedge clk);
      step_valid = 1'b0;
      cfg_we     = 1'b0;
      n = 1;
      while (step_ready !== 1'b1 && n < 40) begin
         if (n == 1) begin
            if (poke == 1) begin
               cfg_we     = 1'b1;
               cfg_thresh = 8'd10;
            end else if (poke == 2) begin
               mem_clear = 1'b1;
            end
         end else begin
            cfg_we    = 1'b0;
            mem_clear = 1'b0;
         end
         @(negedge clk);
         n++;
      end
      cfg_we    = 1'b0;
      mem_clear = 1'b0;
      check("step_ready_after_step", 32'(n), 32'd10);
   endtask

   initial begin
      #200000;
      $display("FAIL global_timeout: got no finish expected finish");
      $fatal(1);
   end

   initial begin
      set_curr(8'd30, 8'd30, 8'd30, 8'd30);
      rst = 1'b1;
      repeat (3) @(negedge clk);
      rst = 1'b0;

      // Reset state.
      check("rst_step_ready",  32'(step_ready),  32'd1);
      check("rst_busy",        32'(busy),        32'd0);
      check("rst_spike_valid", 32'(spike_valid), 32'd0);
      check("rst_spike_out",   32'(spike_out),   32'd0);
      check("rst_curr_addr",   32'(curr_addr),   32'd0);

      // Step 1 with cycle-exact latency checks (membranes -> 30).
      @(negedge clk);
      exp_q.push_back(4'b0000);
      step_valid = 1'b1;
      @(negedge clk);
      step_valid = 1'b0;
      for (int k = 1; k <= 10; k++) begin
         if (k <= 8) check("curr_addr_cycle", 32'(curr_addr), 32'((k - 1) / 2));
         check("spike_valid_cycle", 32'(spike_valid), 32'(k == 9));
         check("step_ready_cycle",  32'(step_ready),  32'(k == 10));
         if (k < 10) @(negedge clk);
      end

      // Steps 2..5: 53, 70, 83, 93 stay below 100; step 6 reaches 100 and fires.
      for (int s = 2; s <= 5; s++) run_step(4'b0000, 1'b0, 0);
      run_step(4'b1111, 1'b0, 0);
      check("spike_out_hold", 32'(spike_out), 32'hF);

      // cfg_we while busy is ignored: 0 + 30 = 30 < 100.
      run_step(4'b0000, 1'b0, 1);
      // cfg in the accept cycle applies: 30 - 7 + 30 = 53 >= 10.
      cfg_thresh = 8'd10;
      cfg_leak   = 3'd2;
      run_step(4'b1111, 1'b1, 0);

      // Saturation with no leak, threshold 255.
      do_cfg(8'd255, 3'd0, 1'b0);
      set_curr(8'd250, 8'd250, 8'd250, 8'd250);
      run_step(4'b0000, 1'b0, 0);                 // membranes 250
      set_curr(8'd255, 8'd0, 8'd4, 8'd5);
      run_step(4'b1001, 1'b0, 0);                 // 255 sat, 250, 254, 255
      do_cfg(8'd0, 3'd0, 1'b0);
      set_curr(8'd0, 8'd0, 8'd0, 8'd0);
      run_step(4'b1111, 1'b0, 0);                 // threshold 0: all fire, all stored 0
      do_cfg(8'd255, 3'd0, 1'b0);
      set_curr(8'd254, 8'd254, 8'd254, 8'd254);
      run_step(4'b0000, 1'b0, 0);                 // 0 + 254 < 255 confirms stored 0

      // mem_clear in IDLE: 254 -> 0, then 5 < 6, then 5 + 1 = 6 fires.
      do_cfg(8'd6, 3'd0, 1'b1);
      set_curr(8'd5, 8'd5, 8'd5, 8'd5);
      run_step(4'b0000, 1'b0, 0);
      set_curr(8'd1, 8'd1, 8'd1, 8'd1);
      run_step(4'b1111, 1'b0, 0);

      // mem_clear while busy is ignored: 5 + 1 = 6 still fires on every neuron.
      set_curr(8'd5, 8'd5, 8'd5, 8'd5);
      run_step(4'b0000, 1'b0, 0);
      set_curr(8'd1, 8'd1, 8'd1, 8'd1);
      run_step(4'b1111, 1'b0, 2);

      // Reset mid-step: immediate return to reset values, no pulse.
      @(negedge clk);
      step_valid = 1'b1;
      @(negedge clk);
      step_valid = 1'b0;
      repeat (2) @(negedge clk);
      rst = 1'b1;
      #1;
      check("midrst_busy",        32'(busy),        32'd0);
      check("midrst_step_ready",  32'(step_ready),  32'd1);
      check("midrst_spike_valid", 32'(spike_valid), 32'd0);
      check("midrst_spike_out",   32'(spike_out),   32'd0);
      check("midrst_curr_addr",   32'(curr_addr),   32'd0);
      repeat (3) @(negedge clk);
      rst = 1'b0;

      // Config back to threshold 100 / leak 2: 30 then 53, no spikes.
      set_curr(8'd30, 8'd30, 8'd30, 8'd30);
      run_step(4'b0000, 1'b0, 0);
      run_step(4'b0000, 1'b0, 0);

      repeat (2) @(negedge clk);
      check("scoreboard_drained", 32'(exp_q.size()), 32'd0);

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
